fft_frame_loader: RTL and testbench
===================================

FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 Parameters SHALL be: N_SAMPLES, default 16, samples per FFT frame; RAM_LATENCY, default 2, cycles from a read issue to valid ram_q; LAST_ADDR, default 32767, final sample address before wrap; PACE_CYCLES, default 33554431, inter-frame hold.
REQ-002 Clk  in  1  system clock (50 MHz); all state changes on its rising edge.
REQ-003 Reset_n  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  level enable; the block begins a frame only while it is high.
REQ-005 ram_addr  out  15  sample RAM read address.
REQ-006 ram_rden  out  1  sample RAM read enable.
REQ-007 ram_q  in  16  signed sample word from RAM.
REQ-008 samp_we  out  1  one-cycle write strobe into the FFT sample bank.
REQ-009 samp_idx  out  4  sample-bank slot, 0..N_SAMPLES-1.
REQ-010 samp_data  out  24  sample-bank write data.
REQ-011 fft_ready  in  1  FFT idle and able to accept a frame.
REQ-012 fft_load  out  1  one-cycle pulse: all N_SAMPLES slots written, start the transform.
REQ-013 fft_done  in  1  FFT frame-completed pulse.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 frame_count  out  16  completed-frame counter.

Function
REQ-016 The FSM SHALL have exactly these states: IDLE, FETCH, WAIT, CAPTURE, LAUNCH, WAIT_FFT, PACE.
REQ-017 IDLE->FETCH SHALL occur when start=1 and fft_ready=1 in the same cycle; otherwise the FSM stays in IDLE.
REQ-018 FETCH SHALL drive ram_rden=1 with ram_addr at the current read address for one cycle, then go to WAIT.
REQ-019 WAIT SHALL hold ram_rden=1 for RAM_LATENCY-1 cycles, then go to CAPTURE.
REQ-020 CAPTURE SHALL last one cycle, asserting samp_we=1, samp_idx=current slot, and samp_data = ram_q sign-extended to 24 bits.
REQ-021 Per-sample cost SHALL be RAM_LATENCY+1 cycles; with defaults, a frame takes 48 cycles from the first FETCH through the last CAPTURE.
REQ-022 In CAPTURE, the read address SHALL increment by 1, wrapping from LAST_ADDR to 0.
REQ-023 In CAPTURE, the slot SHALL increment; after slot N_SAMPLES-1 it SHALL return to 0 and the FSM SHALL go to LAUNCH, otherwise to FETCH.
REQ-024 LAUNCH SHALL assert fft_load for exactly one cycle, then go to WAIT_FFT.
REQ-025 WAIT_FFT SHALL hold until fft_done=1; on that edge frame_count SHALL increment (wrapping 65535->0) and the FSM SHALL leave WAIT_FFT.
REQ-026 fft_done SHALL be ignored in every state other than WAIT_FFT.
REQ-027 Deasserting start mid-frame SHALL NOT abort; the frame completes through WAIT_FFT and PACE, and start is next sampled in IDLE.
REQ-028 The read address SHALL persist across frames so consecutive frames read consecutive RAM words.
REQ-029 Outside the states named above, outputs SHALL be: ram_rden=0 outside FETCH/WAIT; samp_we=0 outside CAPTURE; fft_load=0 outside LAUNCH.
REQ-030 An unreachable FSM encoding SHALL return to IDLE on the next clock.

Reset
REQ-031 While Reset_n=0, regardless of Clk, the block SHALL hold: state=IDLE, ram_addr=0, slot=0, pacing counter=0, frame_count=0.
REQ-032 During reset, all strobes (ram_rden, samp_we, fft_load) SHALL be 0 and busy SHALL be 0.
REQ-033 Reset asserted mid-frame SHALL discard the partial frame with no fft_load; after release, the next frame SHALL start at address 0, slot 0.

Configuration
REQ-034 Macro FRAME_PACING_EN, when defined, SHALL route WAIT_FFT->PACE; PACE counts 0..PACE_CYCLES, then goes to IDLE with the counter cleared.
REQ-035 Without FRAME_PACING_EN, WAIT_FFT SHALL go directly to IDLE, PACE and its counter SHALL not exist, and busy SHALL never reflect pacing.

Verification
REQ-036 The bench SHALL cover the following directed scenarios:
- RAM preloaded addr n = n; start=1, fft_ready=1 -> 16 samp_we pulses at 3-cycle spacing, samp_idx 0..15, samp_data 0..15, then fft_load one cycle after the last CAPTURE.
- ram_q=16'h8001 at a slot -> samp_data=24'hFF8001; ram_q=16'h7FFF -> samp_data=24'h007FFF.
- Read address preset to 32760 by running frames -> the frame reads 32760..32767 then 0..7, and ram_addr=8 afterwards.
- fft_done pulsed during FETCH, then again in WAIT_FFT -> frame_count increments only once, 0->1.
- Reset_n low at slot 7 -> no fft_load; after release, the first FETCH shows ram_addr=0, and frame_count=0.
- With FRAME_PACING_EN and PACE_CYCLES=10, fft_done then start held high -> busy stays high 11 cycles in PACE, then next FETCH two cycles later (IDLE, FETCH); without the macro, FETCH follows IDLE immediately after WAIT_FFT.

Source files
------------

// File: rtl/fft_frame_loader.sv
// Streams N_SAMPLES words from the sample RAM into the FFT sample bank, fires the transform and waits for completion.
// Optional inter-frame pacing state is built when FRAME_PACING_EN is defined.
module fft_frame_loader #(
  parameter int unsigned N_SAMPLES   = 16,
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned LAST_ADDR   = 32767,
  parameter int unsigned PACE_CYCLES = 33554431
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        start,
  output logic [14:0] ram_addr,
  output logic        ram_rden,
  input  logic [15:0] ram_q,
  output logic        samp_we,
  output logic [3:0]  samp_idx,
  output logic [23:0] samp_data,
  input  logic        fft_ready,
  output logic        fft_load,
  input  logic        fft_done,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int unsigned WAIT_W = (RAM_LATENCY > 2) ? $clog2(RAM_LATENCY) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT     = 3'd2,
    CAPTURE  = 3'd3,
    LAUNCH   = 3'd4,
    WAIT_FFT = 3'd5
`ifdef FRAME_PACING_EN
    , PACE   = 3'd6
`endif
  } state_t;

  state_t            state, state_nxt;
  logic [3:0]        slot;
  logic [WAIT_W-1:0] wait_cnt;
  logic              last_slot;
  logic              wait_last;

  assign last_slot = (slot == 4'(N_SAMPLES - 1));
  assign wait_last = (wait_cnt == WAIT_W'(RAM_LATENCY - 2));

`ifdef FRAME_PACING_EN
  localparam int unsigned PACE_W = (PACE_CYCLES > 0) ? $clog2(PACE_CYCLES + 1) : 1;
  logic [PACE_W-1:0] pace_cnt;
  logic              pace_last;

  assign pace_last = (pace_cnt == PACE_W'(PACE_CYCLES));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      pace_cnt <= '0;
    else if (state == PACE)
      pace_cnt <= pace_last ? '0 : pace_cnt + 1'b1;
  end
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start && fft_ready) state_nxt = FETCH;
      // With a single-cycle RAM there is nothing to wait for after the issue.
      FETCH:    state_nxt = (RAM_LATENCY > 1) ? WAIT : CAPTURE;
      WAIT:     if (wait_last) state_nxt = CAPTURE;
      CAPTURE:  state_nxt = last_slot ? LAUNCH : FETCH;
      LAUNCH:   state_nxt = WAIT_FFT;
`ifdef FRAME_PACING_EN
      WAIT_FFT: if (fft_done) state_nxt = PACE;
      PACE:     if (pace_last) state_nxt = IDLE;
`else
      WAIT_FFT: if (fft_done) state_nxt = IDLE;
`endif
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_rden  = (state == FETCH) || (state == WAIT);
    samp_we   = (state == CAPTURE);
    fft_load  = (state == LAUNCH);
    busy      = (state != IDLE);
    samp_idx  = slot;
    samp_data = samp_we ? {{8{ram_q[15]}}, ram_q} : '0;
  end

  // Read address deliberately survives across frames; only reset clears it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ram_addr    <= '0;
      slot        <= '0;
      wait_cnt    <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        FETCH:    wait_cnt <= '0;
        WAIT:     wait_cnt <= wait_cnt + 1'b1;
        CAPTURE: begin
          ram_addr <= (ram_addr == 15'(LAST_ADDR)) ? '0 : ram_addr + 15'd1;
          slot     <= last_slot ? '0 : slot + 4'd1;
        end
        WAIT_FFT: if (fft_done) frame_count <= frame_count + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomised and directed bench for fft_frame_loader against a cycle-offset reference model.
`timescale 1ns/1ps
module tb_fft_frame_loader;

  localparam int NS    = 16;
  localparam int LAT   = 2;
  localparam int SPS   = LAT + 1;
  localparam int FL    = NS * SPS;
  localparam int LASTA = 55;
  localparam int PACE  = 10;

  logic        Clk = 1'b0;
  logic        Reset_n, start, fft_ready, fft_done;
  logic [14:0] ram_addr;
  logic        ram_rden, samp_we, fft_load, busy;
  logic [15:0] ram_q, s1, frame_count;
  logic [3:0]  samp_idx;
  logic [23:0] samp_data;

  logic [15:0] mem [0:32767];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int          k = -1;
  logic [14:0] m_addr = '0;
  logic [15:0] m_fc = '0;

  int          cap_cyc[$];
  int          cap_idx[$];
  int          cap_addr[$];
  logic [23:0] cap_data[$];
  int          load_cyc[$];

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (ram_rden) s1 <= mem[ram_addr];
    ram_q <= s1;
  end

  fft_frame_loader #(
    .N_SAMPLES(NS), .RAM_LATENCY(LAT), .LAST_ADDR(LASTA), .PACE_CYCLES(PACE)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .ram_addr(ram_addr),
    .ram_rden(ram_rden), .ram_q(ram_q), .samp_we(samp_we), .samp_idx(samp_idx),
    .samp_data(samp_data), .fft_ready(fft_ready), .fft_load(fft_load),
    .fft_done(fft_done), .busy(busy), .frame_count(frame_count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: k is the cycle offset inside a frame (-1 = idle, FL = launch,
  // FL+1 = waiting for the FFT, beyond that = pacing).
  initial begin : compare
    bit          e_rden, e_we, e_load, e_busy;
    logic [15:0] v;
    forever begin
      @(negedge Clk);
      cyc++;
      if (!Reset_n) begin
        k = -1; m_addr = '0; m_fc = '0;
        chk("rst_busy", busy, 0);
        chk("rst_rden", ram_rden, 0);
        chk("rst_we", samp_we, 0);
        chk("rst_load", fft_load, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_fc", frame_count, 0);
      end else begin
        e_busy = (k >= 0);
        e_rden = (k >= 0) && (k < FL) && ((k % SPS) != SPS - 1);
        e_we   = (k >= 0) && (k < FL) && ((k % SPS) == SPS - 1);
        e_load = (k == FL);
        chk("busy", busy, e_busy);
        chk("ram_rden", ram_rden, e_rden);
        chk("samp_we", samp_we, e_we);
        chk("fft_load", fft_load, e_load);
        chk("ram_addr", ram_addr, m_addr);
        chk("frame_count", frame_count, m_fc);
        if (e_we) begin
          v = mem[m_addr];
          chk("samp_idx", samp_idx, k / SPS);
          chk("samp_data", samp_data, {{8{v[15]}}, v});
        end
        if (samp_we) begin
          cap_cyc.push_back(cyc);
          cap_idx.push_back(int'(samp_idx));
          cap_addr.push_back(int'(ram_addr));
          cap_data.push_back(samp_data);
        end
        if (fft_load) load_cyc.push_back(cyc);

        if (k < 0) begin
          if (start && fft_ready) k = 0;
        end else if (k < FL) begin
          if ((k % SPS) == SPS - 1) m_addr = (m_addr == 15'(LASTA)) ? 15'd0 : m_addr + 15'd1;
          k++;
        end else if (k == FL) begin
          k++;
        end else if (k == FL + 1) begin
          if (fft_done) begin
            m_fc = m_fc + 16'd1;
`ifdef FRAME_PACING_EN
            k = FL + 2;
`else
            k = -1;
`endif
          end
        end else begin
          if (k - (FL + 2) == PACE) k = -1;
          else k++;
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got %0d of %0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic wait_loads(input int target);
    int g = 0;
    while (load_cyc.size() < target && g < 400) begin tick(1); g++; end
    chk("load_timeout", load_cyc.size(), target);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (busy && g < 200) begin tick(1); g++; end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic do_frame(input bit done_in_fetch, input int fc_before);
    int nl;
    nl = load_cyc.size();
    start = 1'b1; fft_ready = 1'b1;
    tick(1);
    start = 1'b0;
    if (done_in_fetch) begin fft_done = 1'b1; tick(1); fft_done = 1'b0; end
    wait_loads(nl + 1);
    chk("fc_before_done", frame_count, fc_before);
    fft_done = 1'b1; tick(1); fft_done = 1'b0;
    chk("fc_after_done", frame_count, (fc_before + 1) % 65536);
    wait_idle();
  endtask

  initial begin : stim
    int b, nl, pace_n, idle_n, g, ea;
    Reset_n = 1'b0; start = 1'b0; fft_ready = 1'b0; fft_done = 1'b0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i);
    tick(3);
    chk("init_addr", ram_addr, 0);
    chk("init_busy", busy, 0);
    chk("init_fc", frame_count, 0);
    Reset_n = 1'b1;
    tick(2);

    // Frame 1: identity data, stray fft_done during FETCH.
    b = cap_idx.size();
    do_frame(1'b1, 0);
    for (int i = 0; i < NS; i++) begin
      chk("f1_idx", cap_idx[b + i], i);
      chk("f1_data", cap_data[b + i], i);
      chk("f1_addr", cap_addr[b + i], i);
      if (i > 0) chk("f1_gap", cap_cyc[b + i] - cap_cyc[b + i - 1], 3);
    end
    chk("f1_load_gap", load_cyc[load_cyc.size() - 1] - cap_cyc[b + NS - 1], 1);
    chk("f1_fc_once", frame_count, 1);

    // Frame 2: sign extension.
    mem[16] = 16'h8001; mem[17] = 16'h7FFF;
    b = cap_idx.size();
    do_frame(1'b0, 1);
    chk("sext_neg", cap_data[b], 24'hFF8001);
    chk("sext_pos", cap_data[b + 1], 24'h007FFF);

    // Frames 3-4: address wraps from LAST_ADDR back to 0 inside frame 4.
    do_frame(1'b0, 2);
    b = cap_idx.size();
    do_frame(1'b0, 3);
    for (int i = 0; i < NS; i++) begin
      ea = (i < 8) ? 48 + i : i - 8;
      chk("wrap_addr", cap_addr[b + i], ea);
      chk("wrap_data", cap_data[b + i], ea);
    end
    chk("wrap_addr_after", ram_addr, 8);

    // Inter-frame timing with start held high.
    nl = load_cyc.size();
    start = 1'b1; fft_ready = 1'b1;
    tick(1);
    wait_loads(nl + 1);
    fft_done = 1'b1; tick(1); fft_done = 1'b0;
    pace_n = 0; idle_n = 0;
    while (busy && !ram_rden && pace_n < 100) begin pace_n++; tick(1); end
    while (!busy && idle_n < 100) begin idle_n++; tick(1); end
`ifdef FRAME_PACING_EN
    chk("pace_cycles", pace_n, 11);
`else
    chk("pace_cycles", pace_n, 0);
`endif
    chk("idle_cycles", idle_n, 1);
    chk("refetch_rden", ram_rden, 1);
    chk("refetch_addr", ram_addr, 24);
    start = 1'b0;
    wait_loads(nl + 2);
    fft_done = 1'b1; tick(1); fft_done = 1'b0;
    wait_idle();
    chk("fc_six", frame_count, 6);

    // Reset while slot 7 is being fetched.
    b = cap_idx.size();
    start = 1'b1; fft_ready = 1'b1;
    tick(1);
    start = 1'b0;
    g = 0;
    while (cap_idx.size() < b + 7 && g < 100) begin tick(1); g++; end
    chk("mid_slot_reached", cap_idx.size(), b + 7);
    nl = load_cyc.size();
    Reset_n = 1'b0;
    tick(2);
    chk("mid_rst_busy", busy, 0);
    Reset_n = 1'b1;
    tick(3);
    chk("mid_no_load", load_cyc.size(), nl);
    chk("mid_fc_zero", frame_count, 0);
    b = cap_idx.size();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("mid_fetch_rden", ram_rden, 1);
    chk("mid_fetch_addr", ram_addr, 0);
    wait_loads(nl + 1);
    chk("mid_first_idx", cap_idx[b], 0);
    chk("mid_first_addr", cap_addr[b], 0);
    fft_done = 1'b1; tick(1); fft_done = 1'b0;
    wait_idle();
    chk("mid_fc_one", frame_count, 1);

    // Randomised traffic, checked cycle by cycle by the model.
    for (int i = 0; i <= LASTA; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 2500; i++) begin
      start     = ($urandom_range(0, 9) < 7);
      fft_ready = ($urandom_range(0, 9) < 6);
      fft_done  = ($urandom_range(0, 9) < 2);
      Reset_n   = ($urandom_range(0, 599) != 0);
      tick(1);
    end
    Reset_n = 1'b1; start = 1'b0; fft_done = 1'b0;
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
